// File: rtl/song_seq_pkg.sv
// Shared types and constants for the auto-mode song sequencer.
package song_seq_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 5;
  localparam int unsigned DUR_W_DEFAULT  = 26;

  localparam logic [3:0]  NOTE_REST = 4'd0;
  localparam int unsigned DUR_END   = 0;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StEval,
    StPlay,
    StGap,
    StDone
  } seq_state_e;

endpackage

// File: rtl/song_sequencer_if.sv
// Control, song-memory and player-output signals of the song sequencer.
interface song_sequencer_if
  import song_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DUR_W  = DUR_W_DEFAULT
);

  logic              start;
  logic              stop;
  logic              pause;
  logic              loop_en;
  logic [3:0]        note_value;
  logic [DUR_W-1:0]  duration_value;
  logic [ADDR_W-1:0] nxt_auto_memory_location;
  logic              key_on;
  logic [3:0]        key;
  logic              song_done;

  // Sequencer side.
  modport master (
    input  start,
    input  stop,
    input  pause,
    input  loop_en,
    input  note_value,
    input  duration_value,
    output nxt_auto_memory_location,
    output key_on,
    output key,
    output song_done
  );

  // Controller / memory / consumer side.
  modport slave (
    output start,
    output stop,
    output pause,
    output loop_en,
    output note_value,
    output duration_value,
    input  nxt_auto_memory_location,
    input  key_on,
    input  key,
    input  song_done
  );

endinterface

// File: rtl/song_sequencer_note_timer.sv
// Loadable down-counter with hold; `last` flags the final counted cycle.
module note_timer #(
  parameter int unsigned WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             hold,
  output logic             last
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Parks at zero once expired so an idle timer never raises `last` again.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (!hold && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/song_sequencer.sv
// Auto-mode playback: walks song memory, plays each note, inserts a silent gap.
// Define SONG_SEQ_LOOP_EN to let `loop_en` restart the song at the end marker.
module song_sequencer
  import song_seq_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEFAULT,
  parameter int unsigned DUR_W      = DUR_W_DEFAULT,
  parameter int unsigned GAP_CYCLES = 2_500_000
) (
  input logic              clk,
  input logic              rst,
  song_sequencer_if.master bus
);

  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        key_q;

  logic is_marker;
  logic loop_go;
  logic dur_load, dur_hold, dur_last;
  logic gap_load, gap_hold, gap_last;
  logic play_end, gap_end;

  assign is_marker = (bus.duration_value == DUR_W'(DUR_END));

`ifdef SONG_SEQ_LOOP_EN
  assign loop_go = bus.loop_en;
`else
  logic unused_loop_en;
  assign unused_loop_en = bus.loop_en;
  assign loop_go        = 1'b0;
`endif

  assign play_end = (state_q == StPlay) && !bus.pause && dur_last;
  assign gap_end  = (state_q == StGap) && !bus.pause && gap_last;

  assign dur_load = (state_q == StEval) && !is_marker;
  assign dur_hold = (state_q != StPlay) || bus.pause;
  assign gap_load = play_end;
  assign gap_hold = (state_q != StGap) || bus.pause;

  note_timer #(
    .WIDTH(DUR_W)
  ) u_dur_timer (
    .clk  (clk),
    .rst  (rst),
    .load (dur_load),
    .value(bus.duration_value),
    .hold (dur_hold),
    .last (dur_last)
  );

  note_timer #(
    .WIDTH(GapW)
  ) u_gap_timer (
    .clk  (clk),
    .rst  (rst),
    .load (gap_load),
    .value(GapW'(GAP_CYCLES)),
    .hold (gap_hold),
    .last (gap_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stop overrides everything, including start.
  always_comb begin
    state_d = state_q;
    if (bus.stop) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (bus.start) state_d = StRd;
        StRd:    state_d = StEval;
        StEval: begin
          if (!is_marker)   state_d = StPlay;
          else if (loop_go) state_d = StRd;
          else              state_d = StDone;
        end
        StPlay:  if (play_end) state_d = StGap;
        StGap:   if (gap_end) state_d = StEval;
        StDone:  if (bus.start) state_d = StRd;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    bus.key_on                   = (state_q == StPlay) && (key_q != NOTE_REST) && !bus.pause;
    bus.key                      = key_q;
    bus.song_done                = (state_q == StDone);
    bus.nxt_auto_memory_location = addr_q;
  end

  // Address and latched note. The address is bumped when the note ends so the
  // next entry's read completes during the gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      key_q  <= NOTE_REST;
    end else begin
      if (bus.stop || ((state_q == StEval) && is_marker)) begin
        addr_q <= '0;
      end else if (play_end) begin
        addr_q <= addr_q + 1'b1;
      end
      if (dur_load) begin
        key_q <= bus.note_value;
      end
    end
  end

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Playback sequencer for auto mode. It walks the song memory from address 0, reads each (note, duration) entry and holds `key`/`key_on` for that entry's duration. It inserts a fixed silent gap between notes and stops at an end-of-song marker. It sits between the song memory and the display, LED and buzzer consumers, driving the memory address and the `key`/`key_on` pair they consume.

## Interface
Parameters:
- `ADDR_W`, 5, song memory address width (32 entries)
- `DUR_W`, 26, duration width in clock cycles
- `GAP_CYCLES`, 2_500_000, silent inter-note gap in cycles; must be ≥1

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  single-cycle request to begin playback from address 0
- `stop`  in  1  abort playback and return to idle
- `pause`  in  1  level; freezes playback while high
- `loop_en`  in  1  level; restart at the end marker instead of finishing
- `note_value`  in  4  memory read data, note (0 = rest)
- `duration_value`  in  DUR_W  memory read data, cycles (0 = end marker)
- `nxt_auto_memory_location`  out  ADDR_W  memory read address
- `key_on`  out  1  buzzer/LED enable
- `key`  out  4  current note
- `song_done`  out  1  high while finished

## Operation
- The memory is synchronous-read: data for the address driven in cycle N is valid in cycle N+1.
- States: IDLE, RD, EVAL, PLAY, GAP, DONE.
- **IDLE:** address is 0, `key_on` is 0. `start` → RD.
- **RD:** one cycle for read latency → EVAL.
- **EVAL:** samples memory data.
  - `duration_value`==0: if looping (see Configuration), address←0 → RD; otherwise → DONE.
  - Else: latch `key`←`note_value`, load the duration counter, → PLAY.
- **PLAY:** `key_on` = (`key`≠0) and not `pause`. The counter decrements on each unpaused cycle. When it reaches its last cycle, the address increments → GAP.
- **GAP:** `key_on`=0 and `key` holds. Counts `GAP_CYCLES` unpaused cycles, then → EVAL. The incremented address already has its data ready.
- **DONE:** `song_done`=1, `key_on`=0, address=0. `start` → RD.
- Address increment wraps modulo 2^ADDR_W, so 31→0 with no marker.
- `stop` → IDLE from any state. `stop` has priority over `start`.
- `start` outside IDLE/DONE is ignored.
- `pause` in IDLE/RD/EVAL/DONE has no effect.
- `pause` in PLAY/GAP holds both counters and the state, and forces `key_on`=0.

## Timing
- Reset values: all outputs are 0 and the state is IDLE.
- `start` at cycle 0: RD at cycle 1, EVAL at cycle 2, `key_on` first high at cycle 3.
- A duration of D gives exactly D unpaused cycles of PLAY, then exactly `GAP_CYCLES` cycles of GAP.
- The next note's `key_on` rises exactly 1 cycle after GAP ends (the EVAL cycle).
- Entry-to-entry period is D + `GAP_CYCLES` + 1 cycles.
- `stop` or `rst` mid-note: `key_on` is 0 in the next cycle.
- `song_done` rises the cycle after EVAL samples the marker.
- Paused cycles extend PLAY/GAP one-for-one.

## Configuration
- Macro: `SONG_SEQ_LOOP_EN`.
- Defined: at the marker with `loop_en`=1, address←0 and the state → RD.
  - Playback restarts with no `song_done` pulse.
  - With `loop_en`=0, behaviour is as without the macro.
- Undefined: `loop_en` is ignored and the marker always → DONE.

## Structure
- Package `song_seq_pkg` holds:
  - the state enum
  - `ADDR_W`/`DUR_W` defaults
  - `NOTE_REST`=4'd0
  - `DUR_END`=0
- One sub-module, `note_timer`: a loadable down-counter with hold (pause) input and a `last` flag.
  - Instantiated twice: once for the duration, once for the gap.

## Test plan
- Memory {(5,4),(3,2),(x,0)}, `GAP_CYCLES`=2, start at cycle 0:
  - `key`=5 with `key_on` in cycles 3–6
  - off in cycles 7–9
  - `key`=3 with `key_on` in cycles 10–11
  - `song_done` from cycle 15
- Rest entry (0,3): `key_on` stays 0 for 3 cycles, and the address advances normally.
- `pause` held 5 cycles mid-note: `key_on` drops while paused and the note ends 5 cycles later.
- `stop` during GAP: IDLE next cycle, address 0; `start` restarts from entry 0.
- Macro defined, `loop_en`=1, marker at address 2: after the second note, the address returns to 0 and `song_done` never asserts.
- 32 non-marker entries: the address wraps 31→0 and playback continues.
